// File: rtl/buffered_router_pkg.sv
// Shared types for the buffered mesh router: packet layout, port directions,
// the XY route function and the round-robin pick helper.
package buffered_router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;
  localparam int COORD_W   = 4;
  localparam int DATA_W    = 8;

  typedef enum logic [PORT_W-1:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    CTRL_DATA = 2'd0,
    CTRL_DONE = 2'd1
  } ctrl_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // data carries an opaque payload so individual packets can be told apart
  typedef struct packed {
    ctrl_e              ctrl;
    coord_t             addr;
    logic [DATA_W-1:0]  data;
  } pkt_t;

  // Dimension-ordered XY routing; DONE packets leave through done_dir only at the DONE node.
  function automatic dir_e route_fn(input pkt_t pkt, input int x_pos, input int y_pos,
                                    input int done_x, input int done_y, input dir_e done_dir);
    int   ax;
    int   ay;
    dir_e dir;
    ax = int'(pkt.addr.x);
    ay = int'(pkt.addr.y);
    if (pkt.ctrl == CTRL_DONE && x_pos == done_x && y_pos == done_y) dir = done_dir;
    else if (ax < x_pos) dir = WEST;
    else if (ax > x_pos) dir = EAST;
    else if (ay < y_pos) dir = NORTH;
    else if (ay > y_pos) dir = SOUTH;
    else dir = LOCAL;
    return dir;
  endfunction

  // Returns {found, index} of the first set request at or after ptr, wrapping mod NUM_PORTS.
  // The scan runs backwards so the smallest offset from ptr is written last and wins.
  function automatic logic [PORT_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [PORT_W-1:0] ptr);
    logic [PORT_W:0] res;
    int              idx;
    res = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[idx]) res = {1'b1, PORT_W'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/buffered_router_in_fifo.sv
// Per-input packet FIFO. The head is read straight from storage, so a packet
// pushed in one cycle is visible at the head in the next. full/empty come from
// the registered count only; there is no pop bypass.
module router_in_fifo #(
  parameter int  DEPTH = 4,
  parameter type pkt_t = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  pkt_t din,
  output logic full,
  input  logic pop,
  output pkt_t head,
  output logic empty
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/buffered_router.sv
// Mesh router node with an input FIFO per port, XY routing and one
// round-robin arbiter per output. An arbiter that presents a packet the
// downstream does not take locks onto it, keeping valid_out/out_pkt stable
// until the transfer completes.
module buffered_router
  import buffered_router_pkg::*;
#(
  parameter int   X_POS      = 0,
  parameter int   Y_POS      = 0,
  parameter int   FIFO_DEPTH = 4,
  parameter int   DONE_X     = 0,
  parameter int   DONE_Y     = 0,
  parameter dir_e DONE_DIR   = NORTH,
  parameter int   CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] valid_in,
  output logic [NUM_PORTS-1:0] ready_in,
  input  pkt_t                 in_pkt    [NUM_PORTS],
  output logic [NUM_PORTS-1:0] valid_out,
  input  logic [NUM_PORTS-1:0] ready_out,
  output pkt_t                 out_pkt   [NUM_PORTS],
  output logic [CNT_W-1:0]     xfer_cnt  [NUM_PORTS]
);

  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  pkt_t                 head   [NUM_PORTS];

  dir_e                 route  [NUM_PORTS];
  logic [NUM_PORTS-1:0] req    [NUM_PORTS];   // req[o][i]: input i wants output o
  logic [PORT_W:0]      pick   [NUM_PORTS];
  logic [PORT_W-1:0]    gnt    [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;

  logic [PORT_W-1:0]    ptr_q  [NUM_PORTS];
  logic [PORT_W-1:0]    ptr_d  [NUM_PORTS];
  logic [PORT_W-1:0]    gnt_q  [NUM_PORTS];
  logic [PORT_W-1:0]    gnt_d  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_q  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] lock_q, lock_d;

  // ready_in is forced low during reset so nothing is accepted into a clearing FIFO.
  assign ready_in = ~full & {NUM_PORTS{~rst}};
  assign push     = valid_in & ready_in;
  assign xfer_cnt = cnt_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    router_in_fifo #(
      .DEPTH (FIFO_DEPTH),
      .pkt_t (pkt_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .din   (in_pkt[gi]),
      .full  (full[gi]),
      .pop   (pop[gi]),
      .head  (head[gi]),
      .empty (empty[gi])
    );
  end

  // Route every FIFO head and build per-output request vectors and round-robin picks.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = route_fn(head[i], X_POS, Y_POS, DONE_X, DONE_Y, DONE_DIR);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = ~empty[i] & (int'(route[i]) == o);
      end
      pick[o] = rr_pick(req[o], ptr_q[o]);
    end
  end

  // Select the granted input per output (held index when locked) and derive transfers/pops.
  always_comb begin
    pop       = '0;
    xfer      = '0;
    valid_out = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_q[o]) begin
        gnt[o]       = gnt_q[o];
        valid_out[o] = ~rst;
      end else begin
        gnt[o]       = pick[o][PORT_W-1:0];
        valid_out[o] = pick[o][PORT_W] & ~rst;
      end
      out_pkt[o] = valid_out[o] ? head[gnt[o]] : '0;
      xfer[o]    = valid_out[o] & ready_out[o];
      if (xfer[o]) pop[gnt[o]] = 1'b1;
    end
  end

  // Advance pointer and counter on transfer; lock onto the grant while the output stalls.
  always_comb begin
    lock_d = lock_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      ptr_d[o] = ptr_q[o];
      gnt_d[o] = gnt_q[o];
      cnt_d[o] = cnt_q[o];
      if (xfer[o]) begin
        ptr_d[o]  = (gnt[o] == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt[o] + PORT_W'(1);
        lock_d[o] = 1'b0;
        cnt_d[o]  = cnt_q[o] + CNT_W'(1);
      end else if (valid_out[o]) begin
        lock_d[o] = 1'b1;
        gnt_d[o]  = gnt[o];
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        ptr_q[o] <= '0;
        gnt_q[o] <= '0;
        cnt_q[o] <= '0;
      end
    end else begin
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_buffered_router.sv
// Self-checking bench for buffered_router: a scoreboard of expected packets per
// output is filled as stimulus is driven and drained by a negedge monitor.
module tb_buffered_router;
  import buffered_router_pkg::*;

  localparam int P_N = 0;
  localparam int P_S = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  logic clk = 1'b0;
  logic rst;

  logic [4:0]  valid_in, ready_in, valid_out, ready_out;
  pkt_t        in_pkt [NUM_PORTS];
  pkt_t        out_pkt [NUM_PORTS];
  logic [15:0] xfer_cnt [NUM_PORTS];

  logic [4:0]  n0_valid_in, n0_ready_in, n0_valid_out, n0_ready_out;
  pkt_t        n0_in_pkt [NUM_PORTS];
  pkt_t        n0_out_pkt [NUM_PORTS];
  logic [15:0] n0_xfer_cnt [NUM_PORTS];

  logic [4:0]  n1_valid_in, n1_ready_in, n1_valid_out, n1_ready_out;
  pkt_t        n1_in_pkt [NUM_PORTS];
  pkt_t        n1_out_pkt [NUM_PORTS];
  logic [15:0] n1_xfer_cnt [NUM_PORTS];

  int   tests_run = 0;
  int   tests_failed = 0;
  pkt_t exp_q [NUM_PORTS][$];
  pkt_t mon_exp;

  always #5 clk = ~clk;

  buffered_router #(.X_POS(1), .Y_POS(1), .FIFO_DEPTH(4), .DONE_X(0), .DONE_Y(0),
                    .DONE_DIR(NORTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .in_pkt(in_pkt),
    .valid_out(valid_out), .ready_out(ready_out), .out_pkt(out_pkt), .xfer_cnt(xfer_cnt));

  buffered_router #(.X_POS(0), .Y_POS(0), .FIFO_DEPTH(4), .DONE_X(0), .DONE_Y(0),
                    .DONE_DIR(NORTH), .CNT_W(16)) dut_n0 (
    .clk(clk), .rst(rst), .valid_in(n0_valid_in), .ready_in(n0_ready_in), .in_pkt(n0_in_pkt),
    .valid_out(n0_valid_out), .ready_out(n0_ready_out), .out_pkt(n0_out_pkt), .xfer_cnt(n0_xfer_cnt));

  buffered_router #(.X_POS(1), .Y_POS(0), .FIFO_DEPTH(4), .DONE_X(0), .DONE_Y(0),
                    .DONE_DIR(NORTH), .CNT_W(16)) dut_n1 (
    .clk(clk), .rst(rst), .valid_in(n1_valid_in), .ready_in(n1_ready_in), .in_pkt(n1_in_pkt),
    .valid_out(n1_valid_out), .ready_out(n1_ready_out), .out_pkt(n1_out_pkt), .xfer_cnt(n1_xfer_cnt));

  function automatic pkt_t mk(input ctrl_e c, input int x, input int y, input int d);
    pkt_t p;
    p.ctrl   = c;
    p.addr.x = COORD_W'(x);
    p.addr.y = COORD_W'(y);
    p.data   = DATA_W'(d);
    return p;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int o = 0; o < NUM_PORTS; o++) s = s + exp_q[o].size();
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transfer on the main DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (valid_out[o] && ready_out[o]) begin
          tests_run++;
          if (exp_q[o].size() == 0) begin
            tests_failed++;
            $display("FAIL sb_out%0d: got unexpected pkt %h, required none", o, out_pkt[o]);
          end else begin
            mon_exp = exp_q[o].pop_front();
            if (out_pkt[o] !== mon_exp) begin
              tests_failed++;
              $display("FAIL sb_out%0d: got pkt %h, required %h", o, out_pkt[o], mon_exp);
            end else begin
              $display("[TB] out%0d xfer pkt %h", o, out_pkt[o]);
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (pending() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d pkts still pending, required 0", pending());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (ready_in !== 5'b00000) begin tests_failed++; $display("FAIL rst_ready_in: got %b, required 00000", ready_in); end
    tests_run++;
    if (valid_out !== 5'b00000) begin tests_failed++; $display("FAIL rst_valid_out: got %b, required 00000", valid_out); end
    for (int o = 0; o < NUM_PORTS; o++) begin
      tests_run++;
      if (xfer_cnt[o] !== 16'd0) begin tests_failed++; $display("FAIL rst_cnt%0d: got %0d, required 0", o, xfer_cnt[o]); end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready_in !== 5'b11111) begin tests_failed++; $display("FAIL rst_release_ready: got %b, required 11111", ready_in); end
  endtask

  task automatic test_latency();
    pkt_t p;
    tick();
    p = mk(CTRL_DATA, 2, 1, 8'h11);
    in_pkt[P_L] = p;
    valid_in[P_L] = 1'b1;
    exp_q[P_E].push_back(p);
    tick();
    valid_in = '0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 5'b00100 || out_pkt[P_E] !== p) begin
      tests_failed++;
      $display("FAIL latency_out: got valid %b pkt %h, required 00100 pkt %h", valid_out, out_pkt[P_E], p);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (xfer_cnt[P_E] !== 16'd1) begin tests_failed++; $display("FAIL latency_cnt: got %0d, required 1", xfer_cnt[P_E]); end
  endtask

  task automatic test_rr();
    pkt_t p;
    int   srcs [3];
    srcs[0] = P_N; srcs[1] = P_S; srcs[2] = P_W;
    tick();
    for (int c = 0; c < 9; c++) begin
      valid_in = '0;
      if (c < 3) begin
        for (int s = 0; s < 3; s++) begin
          p = mk(CTRL_DATA, 2, 1, 16 * (c + 1) + srcs[s]);
          in_pkt[srcs[s]] = p;
          valid_in[srcs[s]] = 1'b1;
          exp_q[P_E].push_back(p);
        end
      end
      tick();
      valid_in = '0;
      @(negedge clk);
      tests_run++;
      if (valid_out[P_E] !== 1'b1) begin tests_failed++; $display("FAIL rr_busy c%0d: got %b, required 1", c, valid_out[P_E]); end
    end
    tick();
    wait_drain(20);
  endtask

  task automatic test_lock();
    pkt_t a, b;
    tick();
    ready_out[P_E] = 1'b0;
    a = mk(CTRL_DATA, 2, 1, 8'hA1);
    b = mk(CTRL_DATA, 2, 1, 8'hB2);
    in_pkt[P_S] = a;
    valid_in[P_S] = 1'b1;
    exp_q[P_E].push_back(a);
    tick();
    valid_in = '0;
    in_pkt[P_N] = b;
    valid_in[P_N] = 1'b1;
    exp_q[P_E].push_back(b);
    tick();
    valid_in = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (valid_out[P_E] !== 1'b1 || out_pkt[P_E] !== a) begin
        tests_failed++;
        $display("FAIL lock_hold c%0d: got valid %b pkt %h, required 1 pkt %h", c, valid_out[P_E], out_pkt[P_E], a);
      end
      tick();
    end
    ready_out[P_E] = 1'b1;
    wait_drain(10);
  endtask

  task automatic test_fifo_full();
    pkt_t p;
    tick();
    ready_out = '0;
    for (int k = 0; k < 6; k++) begin
      p = mk(CTRL_DATA, 0, 1, 8'h40 + k);
      in_pkt[P_W] = p;
      valid_in[P_W] = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ready_in[P_W] !== (k < 4)) begin
        tests_failed++;
        $display("FAIL full_ready k%0d: got %b, required %b", k, ready_in[P_W], (k < 4));
      end
      if (k < 4) exp_q[P_W].push_back(p);
      tick();
    end
    valid_in = '0;
    @(negedge clk);
    p = mk(CTRL_DATA, 0, 1, 8'h40);
    tests_run++;
    if (valid_out[P_W] !== 1'b1 || out_pkt[P_W] !== p) begin
      tests_failed++;
      $display("FAIL full_head: got valid %b pkt %h, required 1 pkt %h", valid_out[P_W], out_pkt[P_W], p);
    end
    tests_run++;
    if (xfer_cnt[P_E] !== 16'd12) begin tests_failed++; $display("FAIL east_cnt: got %0d, required 12", xfer_cnt[P_E]); end
    tick();
    ready_out = '1;
    wait_drain(20);
    @(negedge clk);
    tests_run++;
    if (xfer_cnt[P_W] !== 16'd4) begin tests_failed++; $display("FAIL west_cnt: got %0d, required 4", xfer_cnt[P_W]); end
  endtask

  task automatic test_done();
    pkt_t p, q;
    tick();
    tests_run++;
    if (n0_ready_in !== 5'b11111 || n1_ready_in !== 5'b11111) begin
      tests_failed++;
      $display("FAIL done_ready: got %b/%b, required 11111/11111", n0_ready_in, n1_ready_in);
    end
    p = mk(CTRL_DONE, 1, 0, 8'hD0);
    n0_in_pkt[P_L] = p; n0_valid_in[P_L] = 1'b1;
    n1_in_pkt[P_L] = p; n1_valid_in[P_L] = 1'b1;
    tick();
    n0_valid_in = '0;
    n1_valid_in = '0;
    @(negedge clk);
    tests_run++;
    if (n0_valid_out !== 5'b00001 || n0_out_pkt[P_N] !== p) begin
      tests_failed++;
      $display("FAIL done_at_node: got valid %b pkt %h, required 00001 pkt %h", n0_valid_out, n0_out_pkt[P_N], p);
    end
    tests_run++;
    if (n1_valid_out !== 5'b10000 || n1_out_pkt[P_L] !== p) begin
      tests_failed++;
      $display("FAIL done_elsewhere: got valid %b pkt %h, required 10000 pkt %h", n1_valid_out, n1_out_pkt[P_L], p);
    end
    tick();
    q = mk(CTRL_DATA, 1, 0, 8'hD1);
    n0_in_pkt[P_L] = q; n0_valid_in[P_L] = 1'b1;
    tick();
    n0_valid_in = '0;
    @(negedge clk);
    tests_run++;
    if (n0_valid_out !== 5'b00100 || n0_out_pkt[P_E] !== q) begin
      tests_failed++;
      $display("FAIL data_at_done_node: got valid %b pkt %h, required 00100 pkt %h", n0_valid_out, n0_out_pkt[P_E], q);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (n0_xfer_cnt[P_N] !== 16'd1 || n0_xfer_cnt[P_E] !== 16'd1 || n1_xfer_cnt[P_L] !== 16'd1) begin
      tests_failed++;
      $display("FAIL done_cnts: got %0d/%0d/%0d, required 1/1/1", n0_xfer_cnt[P_N], n0_xfer_cnt[P_E], n1_xfer_cnt[P_L]);
    end
  endtask

  task automatic test_reset_mid();
    pkt_t a, b;
    tick();
    ready_out = '0;
    in_pkt[P_N] = mk(CTRL_DATA, 2, 1, 8'h71); valid_in[P_N] = 1'b1;
    in_pkt[P_S] = mk(CTRL_DATA, 0, 1, 8'h72); valid_in[P_S] = 1'b1;
    in_pkt[P_E] = mk(CTRL_DATA, 1, 1, 8'h73); valid_in[P_E] = 1'b1;
    tick();
    valid_in = '0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 5'b11100) begin tests_failed++; $display("FAIL mid_buffered: got %b, required 11100", valid_out); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 5'b00000 || ready_in !== 5'b00000 || out_pkt[P_E] !== '0) begin
      tests_failed++;
      $display("FAIL mid_in_rst: got valid %b ready %b pkt %h, required 00000 00000 0", valid_out, ready_in, out_pkt[P_E]);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 5'b00000 || ready_in !== 5'b11111) begin
      tests_failed++;
      $display("FAIL mid_after_rst: got valid %b ready %b, required 00000 11111", valid_out, ready_in);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      tests_run++;
      if (xfer_cnt[o] !== 16'd0) begin tests_failed++; $display("FAIL mid_cnt%0d: got %0d, required 0", o, xfer_cnt[o]); end
    end
    tick();
    ready_out = '1;
    a = mk(CTRL_DATA, 2, 1, 8'h81);
    b = mk(CTRL_DATA, 2, 1, 8'h82);
    in_pkt[P_N] = a; valid_in[P_N] = 1'b1;
    in_pkt[P_S] = b; valid_in[P_S] = 1'b1;
    exp_q[P_E].push_back(a);
    exp_q[P_E].push_back(b);
    tick();
    valid_in = '0;
    wait_drain(10);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = '0;
    ready_out = '1;
    n0_valid_in = '0;
    n1_valid_in = '0;
    n0_ready_out = '1;
    n1_ready_out = '1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_pkt[i] = '0;
      n0_in_pkt[i] = '0;
      n1_in_pkt[i] = '0;
    end
    test_reset();
    test_latency();
    test_rr();
    test_lock();
    test_fifo_full();
    test_done();
    test_reset_mid();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
